// File: rtl/mac_bus_pkg.sv
// Shared types and constants for the RAM/ROM bus slot scheduler.
package mac_bus_pkg;

    typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_VIDEO, OWN_SOUND} owner_t;

    localparam int BUS_PHASES   = 8;
    localparam int SLOT_A_START = 0;
    localparam int SLOT_B_START = 4;

endpackage

// File: rtl/mac_bus_phase_gen.sv
// Bus phase counter with slot-boundary decodes.
// Latency: decodes are combinational from the registered phase.
// Backpressure: none; free-running on the rising clk8 enable.
module mac_bus_phase_gen #(
    parameter int SLOT_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clk8_en_p,
    output logic slot_start,
    output logic slot_b,
    output logic slot_last
);

    localparam int SL_W = $clog2(SLOT_TICKS);
    localparam int PH_W = SL_W + 1;
    localparam logic [SL_W-1:0] LAST_TICK = SL_W'(SLOT_TICKS - 1);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_next;

    assign ph_next = ph + PH_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ph <= '0;
        end else if (clk8_en_p) begin
            ph <= ph_next;
        end
    end

    // A slot starts on the enable that leaves the previous slot's last tick,
    // so the owner register lines up with ph 0..3 / 4..7.
    assign slot_last  = (ph[SL_W-1:0] == LAST_TICK);
    assign slot_start = clk8_en_p && slot_last;
    assign slot_b     = ph_next[PH_W-1];

endmodule

// File: rtl/mac_ram_slot_scheduler.sv
// Shared RAM/ROM bus slot scheduler: slot A sound > video > cpu, slot B cpu only.
// Latency: grant at slot start, data strobe/ack in the slot's last tick (4..8 ticks for CPU).
// Backpressure: requesters wait for a slot; CPU re-arms only after cpu_req drops.
module mac_ram_slot_scheduler
    import mac_bus_pkg::*;
#(
    parameter int ADDR_W     = 21,
    parameter int SLOT_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk8_en_p,
    input  logic              clk8_en_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              video_req,
    input  logic [ADDR_W-1:0] video_addr,
    input  logic              sound_req,
    input  logic [ADDR_W-1:0] sound_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              videoBusControl,
    output logic              cpuBusControl,
    output logic              cycleReady,
    output logic              loadPixels,
    output logic              loadSound,
    output logic              cpu_ack,
    output logic              video_miss
);

    logic   slot_start;
    logic   slot_b;
    logic   slot_last;
    owner_t owner;
    owner_t owner_nxt;
    logic   sound_pend;
    logic   sound_eff;
    logic   cpu_armed;
    logic   cpu_ok;
    logic   cpu_dropped;
    logic   slot_end;
    logic   ack_now;

    mac_bus_phase_gen #(
        .SLOT_TICKS (SLOT_TICKS)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .clk8_en_p  (clk8_en_p),
        .slot_start (slot_start),
        .slot_b     (slot_b),
        .slot_last  (slot_last)
    );

    // A sound pulse landing on the slot-start edge is served immediately.
    always_comb begin
        sound_eff = sound_pend | sound_req;
        cpu_ok    = cpu_req & cpu_armed;
        owner_nxt = OWN_IDLE;
        if (slot_b) begin
            if (cpu_ok) owner_nxt = OWN_CPU;
        end else if (sound_eff) begin
            owner_nxt = OWN_SOUND;
        end else if (video_req) begin
            owner_nxt = OWN_VIDEO;
        end else if (cpu_ok) begin
            owner_nxt = OWN_CPU;
        end
    end

    assign slot_end        = clk8_en_n && slot_last && (owner != OWN_IDLE);
    assign ack_now         = slot_end && (owner == OWN_CPU) && cpu_req && !cpu_dropped;
    assign videoBusControl = (owner == OWN_VIDEO) || (owner == OWN_SOUND);
    assign cpuBusControl   = (owner == OWN_CPU);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= OWN_IDLE;
            mem_addr    <= '0;
            cycleReady  <= 1'b0;
            loadPixels  <= 1'b0;
            loadSound   <= 1'b0;
            cpu_ack     <= 1'b0;
            video_miss  <= 1'b0;
            sound_pend  <= 1'b0;
            cpu_armed   <= 1'b1;
            cpu_dropped <= 1'b0;
        end else begin
            cycleReady <= slot_end;
            loadPixels <= slot_end && (owner == OWN_VIDEO);
            loadSound  <= slot_end && (owner == OWN_SOUND);
            cpu_ack    <= ack_now;

            if (slot_start) begin
                owner       <= owner_nxt;
                cpu_dropped <= 1'b0;
                case (owner_nxt)
                    OWN_CPU:   mem_addr <= cpu_addr;
                    OWN_VIDEO: mem_addr <= video_addr;
                    OWN_SOUND: mem_addr <= sound_addr;
                    default:   ;
                endcase
            end else if (cpuBusControl && !cpu_req) begin
                cpu_dropped <= 1'b1;
            end

            if (slot_start && (owner_nxt == OWN_SOUND)) begin
                sound_pend <= 1'b0;
            end else if (sound_req) begin
                sound_pend <= 1'b1;
            end

            if (slot_start && !slot_b && sound_eff && video_req) begin
                video_miss <= 1'b1;
            end

            // One request, one ack: disarm on ack, re-arm once cpu_req is seen low.
            if (ack_now) begin
                cpu_armed <= 1'b0;
            end else if (clk8_en_p && !cpu_req) begin
                cpu_armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_ram_slot_scheduler.sv
// Directed bench for mac_ram_slot_scheduler; checks every output tick by tick.
module tb_mac_ram_slot_scheduler;

    localparam int ADDR_W = 21;

    // {videoBusControl, cpuBusControl, cycleReady, loadPixels, loadSound, cpu_ack}
    localparam logic [5:0] IDLE      = 6'b000000;
    localparam logic [5:0] CPU_MID   = 6'b010000;
    localparam logic [5:0] CPU_ACK   = 6'b011001;
    localparam logic [5:0] CPU_NOACK = 6'b011000;
    localparam logic [5:0] VID_MID   = 6'b100000;
    localparam logic [5:0] VID_END   = 6'b101100;
    localparam logic [5:0] SND_MID   = 6'b100000;
    localparam logic [5:0] SND_END   = 6'b101010;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk8_en_p;
    logic              clk8_en_n;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              video_req;
    logic [ADDR_W-1:0] video_addr;
    logic              sound_req;
    logic [ADDR_W-1:0] sound_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              videoBusControl;
    logic              cpuBusControl;
    logic              cycleReady;
    logic              loadPixels;
    logic              loadSound;
    logic              cpu_ack;
    logic              video_miss;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_ph = 0;
    logic [ADDR_W-1:0] a_exp;

    always #5 clk = ~clk;

    mac_ram_slot_scheduler #(
        .ADDR_W     (ADDR_W),
        .SLOT_TICKS (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk8_en_p       (clk8_en_p),
        .clk8_en_n       (clk8_en_n),
        .cpu_req         (cpu_req),
        .cpu_addr        (cpu_addr),
        .video_req       (video_req),
        .video_addr      (video_addr),
        .sound_req       (sound_req),
        .sound_addr      (sound_addr),
        .mem_addr        (mem_addr),
        .videoBusControl (videoBusControl),
        .cpuBusControl   (cpuBusControl),
        .cycleReady      (cycleReady),
        .loadPixels      (loadPixels),
        .loadSound       (loadSound),
        .cpu_ack         (cpu_ack),
        .video_miss      (video_miss)
    );

    // One clk8 tick: rising-phase clk (phase advances), then falling-phase clk
    // (strobes for the new phase become visible). sound_req lasts one clk.
    task automatic tick();
        clk8_en_p = 1'b1;
        clk8_en_n = 1'b0;
        @(posedge clk);
        #1;
        sound_req = 1'b0;
        clk8_en_p = 1'b0;
        clk8_en_n = 1'b1;
        @(posedge clk);
        #1;
        if (!reset) tb_ph = (tb_ph + 1) % 8;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] exp);
        tick();
        chk($sformatf("%s ph%0d", tag, tb_ph),
            32'({videoBusControl, cpuBusControl, cycleReady, loadPixels, loadSound, cpu_ack}),
            32'(exp));
    endtask

    task automatic steps(input string tag, input logic [5:0] exp, input int n);
        for (int i = 0; i < n; i++) step(tag, exp);
    endtask

    initial begin
        reset      = 1'b1;
        clk8_en_p  = 1'b0;
        clk8_en_n  = 1'b0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        video_req  = 1'b0;
        video_addr = '0;
        sound_req  = 1'b0;
        sound_addr = '0;

        repeat (3) tick();
        chk("reset outs", 32'({videoBusControl, cpuBusControl, cycleReady, loadPixels, loadSound, cpu_ack}), 32'(IDLE));
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        chk("reset video_miss", 32'(video_miss), 32'h0);
        reset = 1'b0;
        tb_ph = 0;

        // Idle for three full bus cycles.
        steps("idle", IDLE, 24);
        chk("idle mem_addr", 32'(mem_addr), 32'h0);

        // Single CPU access, request raised at ph 1.
        step("cpu1", IDLE);
        cpu_req  = 1'b1;
        cpu_addr = 21'h012345;
        steps("cpu1", IDLE, 2);
        step("cpu1", CPU_MID);
        chk("cpu1 mem_addr", 32'(mem_addr), 32'h012345);
        steps("cpu1", CPU_MID, 2);
        step("cpu1", CPU_ACK);
        steps("cpu held", IDLE, 8);

        // Drop then re-raise: re-granted.
        cpu_req = 1'b0;
        step("cpu2", IDLE);
        cpu_req  = 1'b1;
        cpu_addr = 21'h1ABCDE;
        steps("cpu2", IDLE, 3);
        step("cpu2", CPU_MID);
        chk("cpu2 mem_addr", 32'(mem_addr), 32'h1ABCDE);
        steps("cpu2", CPU_MID, 2);
        step("cpu2", CPU_ACK);

        // Video in slot A, CPU in slot B, every cycle.
        video_req  = 1'b1;
        video_addr = 21'h0F0F00;
        for (int c = 0; c < 3; c++) begin
            cpu_req = 1'b0;
            step("vid", VID_MID);
            chk("vid mem_addr", 32'(mem_addr), 32'h0F0F00);
            cpu_req  = 1'b1;
            a_exp    = 21'h000100 + 21'(c);
            cpu_addr = a_exp;
            steps("vid", VID_MID, 2);
            step("vid", VID_END);
            step("vid cpu", CPU_MID);
            chk("vid cpu mem_addr", 32'(mem_addr), 32'(a_exp));
            steps("vid cpu", CPU_MID, 2);
            step("vid cpu", CPU_ACK);
        end
        chk("video_miss clear", 32'(video_miss), 32'h0);

        // Sound pulse on the slot-A start edge displaces video.
        cpu_req    = 1'b0;
        sound_addr = 21'h1F0000;
        sound_req  = 1'b1;
        step("snd", SND_MID);
        chk("snd mem_addr", 32'(mem_addr), 32'h1F0000);
        chk("video_miss set", 32'(video_miss), 32'h1);
        steps("snd", SND_MID, 2);
        step("snd", SND_END);
        steps("snd slotB", IDLE, 4);
        steps("vid after snd", VID_MID, 3);
        step("vid after snd", VID_END);
        step("idle hold", IDLE);
        chk("idle keeps mem_addr", 32'(mem_addr), 32'h0F0F00);
        steps("idle hold", IDLE, 3);
        chk("video_miss sticky", 32'(video_miss), 32'h1);

        // Two sound pulses before slot A merge into one fetch.
        video_req  = 1'b0;
        sound_addr = 21'h1F0123;
        steps("merge", IDLE, 6);
        sound_req = 1'b1;
        step("merge", IDLE);
        sound_req = 1'b1;
        step("merge", IDLE);
        step("merge", SND_MID);
        chk("merge mem_addr", 32'(mem_addr), 32'h1F0123);
        steps("merge", SND_MID, 2);
        step("merge", SND_END);
        steps("merge after", IDLE, 12);

        // Reset in the middle of a CPU slot.
        cpu_addr = 21'h0AAAAA;
        step("rst cpu", IDLE);
        cpu_req = 1'b1;
        steps("rst cpu", IDLE, 3);
        steps("rst cpu", CPU_MID, 2);
        reset = 1'b1;
        tb_ph = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mid reset outs", 32'({videoBusControl, cpuBusControl, cycleReady, loadPixels, loadSound, cpu_ack}), 32'(IDLE));
        end
        chk("mid reset mem_addr", 32'(mem_addr), 32'h0);
        chk("mid reset video_miss", 32'(video_miss), 32'h0);
        reset = 1'b0;
        steps("post rst", IDLE, 3);
        step("post rst", CPU_MID);
        chk("post rst mem_addr", 32'(mem_addr), 32'h0AAAAA);
        steps("post rst", CPU_MID, 2);
        step("post rst", CPU_ACK);

        // CPU request withdrawn mid-slot: slot completes, no ack.
        cpu_req = 1'b0;
        step("drop", IDLE);
        cpu_req = 1'b1;
        steps("drop", IDLE, 3);
        step("drop", CPU_MID);
        cpu_req = 1'b0;
        steps("drop", CPU_MID, 2);
        step("drop", CPU_NOACK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
